dmem_hs: RTL and testbench

- Parametrised successor to the single-cycle data memory: word-organised RAM behind a valid/ready request channel and a valid/ready response channel.
- Adds configurable access latency, byte-enable writes, response backpressure, and alignment/range error reporting.
- Sits between the multicycle core's load/store stage and data storage; one outstanding request at a time.

---
 rtl/dmem_hs_if.sv | 26 ++
 rtl/dmem_hs.sv | 113 +++++++++++
 tb/tb_dmem_hs.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_hs_if.sv
// Request/response handshake bundle between the load/store stage and dmem_hs.
// The master side issues requests and consumes responses; the slave side is the memory.
interface dmem_hs_if #(
    parameter int DATA_W = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_hs.sv
// Word-organised data RAM behind valid/ready request and response channels,
// with configurable latency, byte-enable stores and alignment/range error reporting.
module dmem_hs #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 1
) (
    input logic     clk,
    input logic     reset,
    dmem_hs_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int BO = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam int HI = BO + IW;
  localparam logic [31:0] BO_MASK = 32'((64'd1 << BO) - 64'd1);
  localparam logic [31:0] HI_MASK = (HI >= 32) ? 32'd0 : ~32'((64'd1 << HI) - 64'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r, state_n;
  logic [2:0]        cnt_r, cnt_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;
  logic              valid_r;
  logic              accept_s;
  logic              err_s;
  logic [IW-1:0]     idx_s;

  // Acceptance is suppressed while reset is held so no store can slip into the array.
  assign accept_s = bus.req_valid && (state_r == IDLE) && !reset;
  assign err_s    = ((bus.req_addr & BO_MASK) != 32'd0) || ((bus.req_addr & HI_MASK) != 32'd0);
  assign idx_s    = bus.req_addr[HI-1:BO];

  assign bus.req_ready = (state_r == IDLE);
  assign bus.rsp_valid = valid_r;
  assign bus.rsp_rdata = rdata_r;
  assign bus.rsp_err   = err_r;

  // Next-state and latency counter logic.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (LATENCY == 1) begin
            state_n = RESP;
            cnt_n   = 3'd0;
          end else begin
            state_n = WAIT;
            cnt_n   = 3'(LATENCY - 2);
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 3'd0) begin
          state_n = RESP;
        end else begin
          cnt_n = cnt_r - 3'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
      end
    endcase
  end

  // State, counter and registered response; load data is a snapshot taken at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
      valid_r <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      valid_r <= (state_n == RESP);
      if (accept_s) begin
        err_r   <= err_s;
        rdata_r <= (bus.req_write || err_s) ? {DATA_W{1'b0}} : mem[idx_s];
      end
    end
  end

  // Byte-lane store into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_s && bus.req_write && !err_s) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.req_be[i]) begin
          mem[idx_s][i*8 +: 8] <= bus.req_wdata[i*8 +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench for dmem_hs: two instances (latency 1 and 4) checked against
// a byte-addressed reference memory held in an associative array.
module tb_dmem_hs;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_hs_if #(.DATA_W(32)) bus1 ();
  dmem_hs_if #(.DATA_W(32)) bus4 ();

  dmem_hs #(.DATA_W(32), .DEPTH(4096), .LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  dmem_hs #(.DATA_W(32), .DEPTH(4096), .LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  logic        rq_valid [2];
  logic        rq_write [2];
  logic [31:0] rq_addr  [2];
  logic [31:0] rq_wdata [2];
  logic [3:0]  rq_be    [2];
  logic        rs_ready [2];
  logic        o_rdy    [2];
  logic        o_vld    [2];
  logic        o_err    [2];
  logic [31:0] o_rdata  [2];

  assign bus1.req_valid = rq_valid[0];
  assign bus1.req_write = rq_write[0];
  assign bus1.req_addr  = rq_addr[0];
  assign bus1.req_wdata = rq_wdata[0];
  assign bus1.req_be    = rq_be[0];
  assign bus1.rsp_ready = rs_ready[0];
  assign bus4.req_valid = rq_valid[1];
  assign bus4.req_write = rq_write[1];
  assign bus4.req_addr  = rq_addr[1];
  assign bus4.req_wdata = rq_wdata[1];
  assign bus4.req_be    = rq_be[1];
  assign bus4.rsp_ready = rs_ready[1];
  assign o_rdy[0]   = bus1.req_ready;
  assign o_vld[0]   = bus1.rsp_valid;
  assign o_err[0]   = bus1.rsp_err;
  assign o_rdata[0] = bus1.rsp_rdata;
  assign o_rdy[1]   = bus4.req_ready;
  assign o_vld[1]   = bus4.rsp_valid;
  assign o_err[1]   = bus4.rsp_err;
  assign o_rdata[1] = bus4.rsp_rdata;

  int n_pass = 0;
  int n_chk  = 0;
  logic [7:0] mbytes [longint];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0000_4000);
  endfunction

  function automatic longint key_of(input int d, input logic [31:0] a);
    return (longint'(d) << 32) | longint'({32'd0, a});
  endfunction

  function automatic logic [7:0] rd_byte(input int d, input logic [31:0] a);
    longint k = key_of(d, a);
    return mbytes.exists(k) ? mbytes[k] : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present a request on a falling edge and hold it through the accepting rising edge.
  task automatic send(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    rq_valid[d] = 1'b1;
    rq_write[d] = wr;
    rq_addr[d]  = a;
    rq_wdata[d] = wd;
    rq_be[d]    = be;
    chk("req_ready_idle", 32'(o_rdy[d]), 32'd1);
    @(posedge clk);
    #1;
    rq_valid[d] = 1'b0;
  endtask

  // One complete transaction: request, latency measurement, optional stall, handshake.
  task automatic xact(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int stall, output logic [31:0] obs);
    bit          e;
    logic [31:0] exp_d;
    int          k;
    bit          seen;
    e     = is_err(a);
    exp_d = 32'd0;
    if (!wr && !e) begin
      for (int i = 0; i < 4; i++) exp_d[i*8 +: 8] = rd_byte(d, a + 32'(i));
    end
    send(d, wr, a, wd, be);
    if (wr && !e) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mbytes[key_of(d, a + 32'(i))] = wd[i*8 +: 8];
      end
    end
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 16) begin
      @(negedge clk);
      k++;
      if (o_vld[d]) seen = 1'b1;
    end
    chk("latency", 32'(k), 32'(lat_of(d)));
    obs = o_rdata[d];
    chk("rsp_rdata", o_rdata[d], exp_d);
    chk("rsp_err", 32'(o_err[d]), 32'(e));
    chk("req_ready_busy", 32'(o_rdy[d]), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(o_vld[d]), 32'd1);
      chk("stall_rdata", o_rdata[d], exp_d);
      chk("stall_err", 32'(o_err[d]), 32'(e));
      chk("stall_ready", 32'(o_rdy[d]), 32'd0);
    end
    rs_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rs_ready[d] = 1'b0;
    chk("valid_drop", 32'(o_vld[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp  [3];
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rq_valid[d] = 1'b0; rq_write[d] = 1'b0; rq_addr[d] = 32'd0;
      rq_wdata[d] = 32'd0; rq_be[d] = 4'd0; rs_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", 32'(o_vld[d]), 32'd0);
      chk("reset_rdata", o_rdata[d], 32'd0);
      chk("reset_err", 32'(o_err[d]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(o_rdy[0]), 32'd1);

    xact(0, 1'b0, 32'h0, 32'd0, 4'h0, 0, obs);
    chk("plan_load0", obs, 32'h0000_0000);

    xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, obs);
    xact(0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 1, obs);
    xact(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, obs);
    chk("plan_merge", obs, 32'hDEAD_BEAA);

    xact(1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'b1111, 0, obs);
    xact(1, 1'b0, 32'h20, 32'd0, 4'h0, 3, obs);
    chk("plan_lat4_load", obs, 32'hCAFE_F00D);

    xact(0, 1'b0, 32'h13, 32'd0, 4'h0, 0, obs);
    xact(0, 1'b0, 32'h4000, 32'd0, 4'h0, 0, obs);
    xact(0, 1'b1, 32'h0, 32'h1122_3344, 4'b1111, 0, obs);
    xact(0, 1'b1, 32'h4000, 32'hFFFF_FFFF, 4'b1111, 0, obs);
    xact(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0000, 0, obs);
    xact(0, 1'b0, 32'h0, 32'd0, 4'h0, 0, obs);
    chk("plan_oor_store", obs, 32'h1122_3344);

    // Reset two cycles into a latency-4 store; the store must stay committed.
    send(1, 1'b1, 32'h30, 32'h1234_5678, 4'b1111);
    for (int i = 0; i < 4; i++) mbytes[key_of(1, 32'h30 + 32'(i))] = 8'(32'h1234_5678 >> (8 * i));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    chk("midreset_valid", 32'(o_vld[1]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_ready", 32'(o_rdy[1]), 32'd1);
    chk("midreset_valid_after", 32'(o_vld[1]), 32'd0);
    xact(1, 1'b0, 32'h30, 32'd0, 4'h0, 0, obs);
    chk("plan_reset_commit", obs, 32'h1234_5678);

    // Back-to-back loads with req_valid and rsp_ready held high.
    for (int j = 0; j < 3; j++) begin
      b2b_addr[j] = 32'h40 + 32'(4 * j);
      b2b_exp[j]  = $urandom;
      xact(0, 1'b1, b2b_addr[j], b2b_exp[j], 4'b1111, 0, obs);
    end
    b2b_addr[3] = 32'h0;
    @(negedge clk);
    rq_valid[0] = 1'b1; rq_write[0] = 1'b0; rq_addr[0] = b2b_addr[0]; rs_ready[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("b2b_ready", 32'(o_rdy[0]), 32'd1);
      @(posedge clk);
      #1;
      rq_addr[0] = b2b_addr[j+1];
      @(negedge clk);
      chk("b2b_valid", 32'(o_vld[0]), 32'd1);
      chk("b2b_rdata", o_rdata[0], b2b_exp[j]);
      chk("b2b_busy", 32'(o_rdy[0]), 32'd0);
      @(posedge clk);
      #1;
      chk("b2b_drop", 32'(o_vld[0]), 32'd0);
      @(negedge clk);
    end
    rq_valid[0] = 1'b0;
    rs_ready[0] = 1'b0;

    // Random traffic on both instances against the reference memory.
    for (int n = 0; n < 60; n++) begin
      int          d;
      int          kind;
      logic [31:0] a;
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      a    = 32'(4 * $urandom_range(0, 31));
      if (kind == 8) a = a + 32'($urandom_range(1, 3));
      if (kind == 9) a = a | (32'h1 << $urandom_range(14, 31));
      xact(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           int'($urandom_range(0, 2)), obs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
